// File: rtl/emu_dt_pkg.sv
// Shared types and helpers for the emulator timestep arbiter.
// Mode and state enums are prefixed because both contain a HALT member.
package emu_dt_pkg;

  typedef logic [31:0] dt_t;

  typedef enum logic [1:0] {
    MODE_HALT = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_STEP = 2'd2
  } emu_mode_e;

  typedef enum logic [1:0] {
    ST_HALT,
    ST_RUN,
    ST_STEP_ISSUE,
    ST_DONE
  } emu_state_e;

  // Index width that never collapses to zero bits for a single channel.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/emu_dt_min_tree.sv
// Registered min/argmin reduction over the channel requests; one register per tree level.
// Disabled channels and power-of-two padding present DT_MAX so they never beat a real request.
module emu_dt_min_tree
  import emu_dt_pkg::*;
#(
  parameter int                   N_CH     = 4,
  parameter int                   DT_WIDTH = 32,
  parameter logic [DT_WIDTH-1:0]  DT_MAX   = '1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_CH-1:0][DT_WIDTH-1:0]      dt_req,
  input  logic [N_CH-1:0]                    ch_en,
  output logic [DT_WIDTH-1:0]                m,
  output logic [clog2_min1(N_CH)-1:0]        idx
);

  localparam int IW = clog2_min1(N_CH);
  localparam int LV = $clog2(N_CH);
  localparam int P  = 1 << LV;

  for (genvar gi = 0; gi <= LV; gi++) begin : g_lvl
    localparam int W = P >> gi;
    logic [DT_WIDTH-1:0] lvl_dt [W];
    logic [IW-1:0]       lvl_ix [W];

    if (gi == 0) begin : g_leaf
      for (genvar gj = 0; gj < W; gj++) begin : g_ch
        if (gj < N_CH) begin : g_real
          assign lvl_dt[gj] = ch_en[gj] ? dt_req[gj] : DT_MAX;
          assign lvl_ix[gj] = IW'(gj);
        end else begin : g_pad
          assign lvl_dt[gj] = DT_MAX;
          assign lvl_ix[gj] = '0;
        end
      end
    end else begin : g_node
      for (genvar gj = 0; gj < W; gj++) begin : g_pair
        logic [DT_WIDTH-1:0] dt_d, dt_q;
        logic [IW-1:0]       ix_d, ix_q;

        // Right operand must be strictly smaller to win, so ties go to the lower index.
        always_comb begin
          dt_d = g_lvl[gi-1].lvl_dt[2*gj];
          ix_d = g_lvl[gi-1].lvl_ix[2*gj];
          if (g_lvl[gi-1].lvl_dt[2*gj+1] < g_lvl[gi-1].lvl_dt[2*gj]) begin
            dt_d = g_lvl[gi-1].lvl_dt[2*gj+1];
            ix_d = g_lvl[gi-1].lvl_ix[2*gj+1];
          end
        end

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            dt_q <= DT_MAX;
            ix_q <= '0;
          end else begin
            dt_q <= dt_d;
            ix_q <= ix_d;
          end
        end

        assign lvl_dt[gj] = dt_q;
        assign lvl_ix[gj] = ix_q;
      end
    end
  end

  // The top level registers m into dt_out, which completes the L-cycle latency.
  assign m   = g_lvl[LV].lvl_dt[0];
  assign idx = g_lvl[LV].lvl_ix[0];

endmodule

// File: rtl/emu_dt_arbiter.sv
// Multi-channel timestep arbiter: min-reduces channel dt requests, issues dt under
// HALT/RUN/STEP control, accumulates emulated time and honours a stop-at-time limit.
module emu_dt_arbiter
  import emu_dt_pkg::*;
#(
  parameter int                   N_CH       = 4,
  parameter int                   DT_WIDTH   = 32,
  parameter int                   TIME_WIDTH = 64,
  parameter logic [DT_WIDTH-1:0]  DT_MAX     = '1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_CH-1:0][DT_WIDTH-1:0]      dt_req,
  input  logic [N_CH-1:0]                    ch_en,
  input  logic [1:0]                         mode,
  input  logic                               step,
  input  logic                               stop_en,
  input  logic [TIME_WIDTH-1:0]              stop_time,
  output logic [DT_WIDTH-1:0]                dt_out,
  output logic                               dt_valid,
  output logic [clog2_min1(N_CH)-1:0]        winner,
  output logic [TIME_WIDTH-1:0]              emu_time,
  output logic                               done
);

  localparam int IW = clog2_min1(N_CH);
  localparam int L  = $clog2(N_CH) + 1;
  localparam int FW = $clog2(L + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(L);

  logic [DT_WIDTH-1:0]   m;
  logic [IW-1:0]         idx;

  logic [FW-1:0]         fill_q, fill_d;
  emu_state_e            state_q, state_d;
  logic [DT_WIDTH-1:0]   dt_out_q, dt_out_d;
  logic [IW-1:0]         winner_q, winner_d;
  logic [TIME_WIDTH-1:0] emu_time_q, emu_time_d;
  logic                  done_q, done_d;
  logic                  step_q;

  logic                  primed;
  logic                  step_rise;
  logic                  issue_en;
  logic                  at_limit;
  logic                  limit_hit;
  logic [TIME_WIDTH:0]   time_sum;
  logic [TIME_WIDTH:0]   reach_sum;
  logic [DT_WIDTH-1:0]   room;
  logic [DT_WIDTH-1:0]   issue_dt;

  emu_dt_min_tree #(
    .N_CH     (N_CH),
    .DT_WIDTH (DT_WIDTH),
    .DT_MAX   (DT_MAX)
  ) u_tree (
    .clk    (clk),
    .rst_n  (rst_n),
    .dt_req (dt_req),
    .ch_en  (ch_en),
    .m      (m),
    .idx    (idx)
  );

  always_comb begin
    fill_d    = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
    // dt_out registered this edge is the first meaningful one once fill reaches L.
    primed    = (fill_d == FILL_MAX);
    step_rise = step & ~step_q;

    time_sum   = {1'b0, emu_time_q} + {{(TIME_WIDTH + 1 - DT_WIDTH){1'b0}}, dt_out_q};
    emu_time_d = time_sum[TIME_WIDTH] ? '1 : time_sum[TIME_WIDTH-1:0];

    // The limit is judged against the time after the dt now on dt_out is applied.
    reach_sum = {1'b0, emu_time_d} + {{(TIME_WIDTH + 1 - DT_WIDTH){1'b0}}, m};
    at_limit  = (emu_time_d >= stop_time);
    limit_hit = stop_en && primed && (reach_sum >= {1'b0, stop_time});
    room      = DT_WIDTH'(stop_time - emu_time_d);
    issue_dt  = !limit_hit ? m : (at_limit ? '0 : room);

    state_d  = state_q;
    issue_en = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (stop_en && primed && at_limit)                 state_d = ST_DONE;
        else if (mode == MODE_RUN)                         state_d = ST_RUN;
        else if (mode == MODE_STEP && step_rise)           state_d = ST_STEP_ISSUE;
      end
      ST_RUN: begin
        issue_en = 1'b1;
        if (limit_hit)                                     state_d = ST_DONE;
        else if (mode != MODE_RUN)                         state_d = ST_HALT;
      end
      ST_STEP_ISSUE: begin
        issue_en = 1'b1;
        state_d  = limit_hit ? ST_DONE : ST_HALT;
      end
      default: state_d = ST_DONE;
    endcase

    dt_out_d = (primed && issue_en) ? issue_dt : '0;
    winner_d = primed ? idx : '0;
    done_d   = done_q | (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q     <= '0;
      state_q    <= ST_HALT;
      dt_out_q   <= '0;
      winner_q   <= '0;
      emu_time_q <= '0;
      done_q     <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      fill_q     <= fill_d;
      state_q    <= state_d;
      dt_out_q   <= dt_out_d;
      winner_q   <= winner_d;
      emu_time_q <= emu_time_d;
      done_q     <= done_d;
      step_q     <= step;
    end
  end

  assign dt_out   = dt_out_q;
  assign dt_valid = (fill_q == FILL_MAX);
  assign winner   = winner_q;
  assign emu_time = emu_time_q;
  assign done     = done_q;

endmodule

// File: tb/tb_emu_dt_arbiter.sv
// Directed bench for emu_dt_arbiter (N_CH=4, L=3): pipeline fill, tie-break, STEP,
// stop-at-time clamp and asynchronous reset, with a running emulated-time model.
module tb_emu_dt_arbiter;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [3:0][31:0]  dt_req;
  logic [3:0]        ch_en;
  logic [1:0]        mode;
  logic              step;
  logic              stop_en;
  logic [63:0]       stop_time;
  logic [31:0]       dt_out;
  logic              dt_valid;
  logic [1:0]        winner;
  logic [63:0]       emu_time;
  logic              done;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_time;
  logic [31:0] exp_dt;

  emu_dt_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dt_req    (dt_req),
    .ch_en     (ch_en),
    .mode      (mode),
    .step      (step),
    .stop_en   (stop_en),
    .stop_time (stop_time),
    .dt_out    (dt_out),
    .dt_valid  (dt_valid),
    .winner    (winner),
    .emu_time  (emu_time),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges, hold two edges, release just after an edge.
  task automatic hold_reset();
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_time = 64'd0;
    exp_dt   = 32'd0;
  endtask

  // Advance one cycle and update the time model with the dt that was on dt_out.
  task automatic model_tick(input logic [31:0] next_dt);
    tick();
    exp_time = exp_time + {32'd0, exp_dt};
    exp_dt   = next_dt;
  endtask

  task automatic test_reset();
    dt_req = '0; ch_en = '0; mode = 2'd0; step = 1'b0; stop_en = 1'b0; stop_time = '0;
    #3 rst_n = 1'b0;
    #1;
    checks++; if (dt_out !== 32'd0)   begin failures++; $display("FAIL reset_dt_out: got %0h expected 0", dt_out); end
    checks++; if (dt_valid !== 1'b0)  begin failures++; $display("FAIL reset_dt_valid: got %0b expected 0", dt_valid); end
    checks++; if (winner !== 2'd0)    begin failures++; $display("FAIL reset_winner: got %0d expected 0", winner); end
    checks++; if (emu_time !== 64'd0) begin failures++; $display("FAIL reset_emu_time: got %0h expected 0", emu_time); end
    checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done: got %0b expected 0", done); end
    $display("reset: dt_out=%0h dt_valid=%0b winner=%0d emu_time=%0h done=%0b", dt_out, dt_valid, winner, emu_time, done);
  endtask

  task automatic test_run_tie();
    dt_req[0] = 32'd40; dt_req[1] = 32'd25; dt_req[2] = 32'd25; dt_req[3] = 32'd90;
    ch_en = 4'b1111; mode = 2'd1; step = 1'b0; stop_en = 1'b0;
    hold_reset();
    for (int c = 1; c <= 6; c++) begin
      model_tick((c >= 3) ? 32'd25 : 32'd0);
      checks++; if (dt_valid !== (c >= 3)) begin failures++; $display("FAIL run_valid c=%0d: got %0b expected %0b", c, dt_valid, (c >= 3)); end
      checks++; if (dt_out !== exp_dt)     begin failures++; $display("FAIL run_dt c=%0d: got %0d expected %0d", c, dt_out, exp_dt); end
      checks++; if (winner !== ((c >= 3) ? 2'd1 : 2'd0)) begin failures++; $display("FAIL run_winner c=%0d: got %0d expected %0d", c, winner, (c >= 3) ? 1 : 0); end
      checks++; if (emu_time !== exp_time) begin failures++; $display("FAIL run_time c=%0d: got %0d expected %0d", c, emu_time, exp_time); end
      $display("run c=%0d: dt_valid=%0b dt_out=%0d winner=%0d emu_time=%0d", c, dt_valid, dt_out, winner, emu_time);
    end
  endtask

  task automatic test_drop();
    dt_req[1] = 32'd10;
    for (int k = 1; k <= 4; k++) begin
      model_tick((k >= 3) ? 32'd10 : 32'd25);
      checks++; if (dt_out !== exp_dt)     begin failures++; $display("FAIL drop_dt k=%0d: got %0d expected %0d", k, dt_out, exp_dt); end
      checks++; if (emu_time !== exp_time) begin failures++; $display("FAIL drop_time k=%0d: got %0d expected %0d", k, emu_time, exp_time); end
      $display("drop k=%0d: dt_out=%0d winner=%0d emu_time=%0d", k, dt_out, winner, emu_time);
    end
    checks++; if (winner !== 2'd1) begin failures++; $display("FAIL drop_winner: got %0d expected 1", winner); end
  endtask

  task automatic test_all_disabled();
    ch_en = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      model_tick((k >= 3) ? 32'hFFFF_FFFF : 32'd10);
      checks++; if (dt_out !== exp_dt) begin failures++; $display("FAIL dis_dt k=%0d: got %0h expected %0h", k, dt_out, exp_dt); end
      checks++; if (winner !== ((k >= 3) ? 2'd0 : 2'd1)) begin failures++; $display("FAIL dis_winner k=%0d: got %0d expected %0d", k, winner, (k >= 3) ? 0 : 1); end
      checks++; if (emu_time !== exp_time) begin failures++; $display("FAIL dis_time k=%0d: got %0h expected %0h", k, emu_time, exp_time); end
      $display("disabled k=%0d: dt_out=%0h winner=%0d emu_time=%0h", k, dt_out, winner, emu_time);
    end
  endtask

  task automatic test_halt();
    mode = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      model_tick((k >= 2) ? 32'd0 : 32'hFFFF_FFFF);
      checks++; if (dt_out !== exp_dt)     begin failures++; $display("FAIL halt_dt k=%0d: got %0h expected %0h", k, dt_out, exp_dt); end
      checks++; if (emu_time !== exp_time) begin failures++; $display("FAIL halt_time k=%0d: got %0h expected %0h", k, emu_time, exp_time); end
      $display("halt k=%0d: dt_out=%0h emu_time=%0h", k, dt_out, emu_time);
    end
  endtask

  task automatic test_step();
    for (int i = 0; i < 4; i++) dt_req[i] = 32'd100;
    ch_en = 4'b1111; mode = 2'd2; step = 1'b0; stop_en = 1'b0;
    hold_reset();
    repeat (4) model_tick(32'd0);
    for (int i = 0; i <= 10; i++) begin
      step = (i == 0 || i == 5);
      model_tick((i == 1 || i == 6) ? 32'd100 : 32'd0);
      checks++; if (dt_out !== exp_dt) begin failures++; $display("FAIL step_dt i=%0d: got %0d expected %0d", i, dt_out, exp_dt); end
      $display("step i=%0d: step=%0b dt_out=%0d emu_time=%0d", i, step, dt_out, emu_time);
    end
    step = 1'b0;
    checks++; if (emu_time !== 64'd200) begin failures++; $display("FAIL step_time: got %0d expected 200", emu_time); end
    for (int i = 0; i <= 5; i++) begin
      step = (i < 3);
      model_tick((i == 1) ? 32'd100 : 32'd0);
      checks++; if (dt_out !== exp_dt) begin failures++; $display("FAIL hold_dt i=%0d: got %0d expected %0d", i, dt_out, exp_dt); end
      $display("step_hold i=%0d: step=%0b dt_out=%0d emu_time=%0d", i, step, dt_out, emu_time);
    end
    step = 1'b0;
    checks++; if (emu_time !== 64'd300) begin failures++; $display("FAIL hold_time: got %0d expected 300", emu_time); end
  endtask

  task automatic test_stop();
    for (int i = 0; i < 4; i++) dt_req[i] = 32'd100;
    ch_en = 4'b1111; mode = 2'd1; step = 1'b0; stop_en = 1'b1; stop_time = 64'd250;
    hold_reset();
    for (int c = 1; c <= 8; c++) begin
      model_tick((c == 3 || c == 4) ? 32'd100 : ((c == 5) ? 32'd50 : 32'd0));
      checks++; if (dt_out !== exp_dt)     begin failures++; $display("FAIL stop_dt c=%0d: got %0d expected %0d", c, dt_out, exp_dt); end
      checks++; if (done !== (c >= 5))     begin failures++; $display("FAIL stop_done c=%0d: got %0b expected %0b", c, done, (c >= 5)); end
      checks++; if (emu_time !== exp_time) begin failures++; $display("FAIL stop_time c=%0d: got %0d expected %0d", c, emu_time, exp_time); end
      $display("stop c=%0d: dt_out=%0d done=%0b emu_time=%0d", c, dt_out, done, emu_time);
    end
    checks++; if (emu_time !== 64'd250) begin failures++; $display("FAIL stop_final: got %0d expected 250", emu_time); end
  endtask

  task automatic test_reset_mid();
    #3 rst_n = 1'b0;
    #1;
    checks++; if (done !== 1'b0)      begin failures++; $display("FAIL mid_done: got %0b expected 0", done); end
    checks++; if (emu_time !== 64'd0) begin failures++; $display("FAIL mid_time: got %0d expected 0", emu_time); end
    checks++; if (dt_valid !== 1'b0)  begin failures++; $display("FAIL mid_valid: got %0b expected 0", dt_valid); end
    checks++; if (dt_out !== 32'd0)   begin failures++; $display("FAIL mid_dt: got %0d expected 0", dt_out); end
    $display("reset_mid: dt_out=%0d dt_valid=%0b emu_time=%0d done=%0b", dt_out, dt_valid, emu_time, done);
    stop_en = 1'b0; mode = 2'd1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_time = 64'd0;
    exp_dt   = 32'd0;
    for (int c = 1; c <= 5; c++) begin
      model_tick((c >= 3) ? 32'd100 : 32'd0);
      checks++; if (dt_valid !== (c >= 3)) begin failures++; $display("FAIL rerun_valid c=%0d: got %0b expected %0b", c, dt_valid, (c >= 3)); end
      checks++; if (dt_out !== exp_dt)     begin failures++; $display("FAIL rerun_dt c=%0d: got %0d expected %0d", c, dt_out, exp_dt); end
      checks++; if (emu_time !== exp_time) begin failures++; $display("FAIL rerun_time c=%0d: got %0d expected %0d", c, emu_time, exp_time); end
      $display("rerun c=%0d: dt_valid=%0b dt_out=%0d emu_time=%0d", c, dt_valid, dt_out, emu_time);
    end
  endtask

  initial begin
    test_reset();
    test_run_tie();
    test_drop();
    test_all_disabled();
    test_halt();
    test_step();
    test_stop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/emu_dt_arbiter.md
Name: emu_dt_arbiter

Overview:
- Multi-channel timestep manager for the FPGA emulator.
- Each analog/digital model channel requests its largest tolerable dt.
- The block reduces the enabled requests to a global minimum through a registered pipeline and issues the result as the emulator dt.
- It accumulates emulated time and supports run, halt, single-step and stop-at-time modes.
- It sits beside the emulator interface and drives its dt field; it generalises the single fixed 32-bit dt to N channels with control.

Parameters:
- N_CH, 4, number of requesting channels (>=1)
- DT_WIDTH, 32, width of each dt request and of dt_out
- TIME_WIDTH, 64, width of the emulated-time accumulator
- DT_MAX, all-ones of DT_WIDTH, dt issued when no channel is enabled

Ports:
- clk  in  1  emulator clock
- rst_n  in  1  asynchronous active-low reset
- dt_req  in  N_CH x DT_WIDTH  per-channel requested dt
- ch_en  in  N_CH  per-channel enable; a disabled channel is ignored
- mode  in  2  0=HALT, 1=RUN, 2=STEP, 3=reserved (treated as HALT)
- step  in  1  single-cycle pulse; in STEP mode, advances exactly one dt
- stop_en  in  1  enables the stop-at-time limit
- stop_time  in  TIME_WIDTH  absolute time limit
- dt_out  out  DT_WIDTH  dt applied this cycle (0 = time frozen)
- dt_valid  out  1  pipeline primed; dt_out is meaningful
- winner  out  $clog2(N_CH) (min 1)  index of the channel that set dt_out
- emu_time  out  TIME_WIDTH  accumulated emulated time
- done  out  1  sticky; stop_time has been reached

Behaviour:
- Reset (async assert, sync release):
  - dt_out=0, dt_valid=0, winner=0, emu_time=0, done=0.
  - All pipeline registers = DT_MAX with index 0.
  - Fill counter = 0; FSM = HALT.
- Reduction pipeline:
  - Disabled channels present DT_MAX.
  - Pairwise min tree with one register per level.
  - Tie: the lower index wins.
  - Latency L = $clog2(N_CH)+1 cycles from dt_req/ch_en sample to dt_out. For N_CH=1, L=1.
- Fill counter:
  - Counts to L after reset, then saturates; dt_valid=1 from then on.
  - While dt_valid=0, dt_out is forced to 0 regardless of mode.
- FSM states HALT, RUN, STEP_ISSUE, DONE; mode is sampled every cycle.
  - HALT: dt_out=0. mode=RUN goes to RUN. mode=STEP with step=1 goes to STEP_ISSUE.
  - RUN: dt_out = tree result m. mode≠RUN goes to HALT next cycle.
  - STEP_ISSUE: dt_out=m for exactly one cycle, then HALT, even if step is held high.
  - DONE: dt_out=0. Exits only via reset.
- Output timing: dt_out takes effect the cycle after the FSM enters the state. Any state change is reflected in dt_out one cycle later.
- Time accumulation: emu_time <= emu_time + dt_out each cycle, zero-extended, saturating at all-ones.
- Stop limit: when stop_en=1 and emu_time + m >= stop_time:
  - the issued dt is clamped to stop_time - emu_time (may be 0);
  - FSM goes to DONE and done=1 on the same cycle the clamped dt is issued;
  - if emu_time >= stop_time already, dt=0 and the FSM goes to DONE immediately.
- Boundary conditions:
  - All channels disabled: m = DT_MAX, winner = 0.
  - Requests of 0 are legal; they freeze time while in RUN.
  - step while in RUN is ignored.
  - Reset mid-operation clears everything, including done.
  - winner tracks the winning index through the same pipeline as m and is registered alongside dt_out.

Decomposition:
- Shared package emu_dt_pkg:
  - dt_t typedef (logic [31:0]);
  - emu_mode_e enum {HALT, RUN, STEP};
  - FSM state enum;
  - function clog2_min1.
- Sub-module emu_dt_min_tree (parameters N_CH, DT_WIDTH, DT_MAX):
  - registered min/argmin tree;
  - outputs m and idx with latency L.
- The top level holds the fill counter, FSM, clamp logic and time accumulator.

Test Plan:
- Reset then mode=RUN, N_CH=4, all enabled, dt_req={40,25,25,90}: dt_valid rises at cycle 3; dt_out=25, winner=1 (tie goes to the lower index); emu_time grows by 25 per cycle.
- ch_en=4'b0000 in RUN: after L=3 cycles dt_out = 0xFFFF_FFFF and winner=0; emu_time steps by that amount.
- mode=STEP, dt_req all 100, step pulsed twice 5 cycles apart: exactly two cycles with dt_out=100; emu_time=200; dt_out=0 otherwise. Holding step high for 3 cycles still yields one issue.
- stop_en=1, stop_time=250, RUN, min dt=100: dt_out sequence 100,100,50,0,...; done=1 on the cycle dt=50 is issued; emu_time=250 and remains there.
- Drop the winning channel's request from 25 to 10 mid-RUN: dt_out changes exactly L cycles later; switching mode to HALT gives dt_out=0 on the following cycle.
- Assert rst_n low in DONE mid-run: all outputs return to reset values asynchronously; after release and mode=RUN, dt_valid is again delayed by L cycles.
